// File: rtl/spi_reg_slave.sv
// SPI mode-0 register slave: synchronized SPI inputs, 16-bit instruction, MSB-first data
// bytes with address auto-decrement, and a shadow/active clock-divide register pair.
module spi_reg_slave #(
  parameter logic [7:0] CHIP_ID     = 8'h82,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       csb,
  input  logic       sdi,
  output logic       sdo,
  output logic       sdo_en,
  output logic [7:0] register_value,
  output logic       transfer_done,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_INSTR, S_DATA} state_t;

  state_t r_state, w_next;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_csb_sync, r_sdi_sync;
  logic        r_sclk_d, r_csb_d;
  logic [3:0]  r_bit_cnt;
  logic [14:0] r_shift;
  logic [6:0]  r_wshift;
  logic [7:0]  r_oshift;
  logic        r_sdo, r_rw;
  logic [1:0]  r_w, r_byte_cnt;
  logic [12:0] r_addr;
  logic [7:0]  r_cfg, r_shadow;
  logic        r_xfer_pend, r_srst_pend;

  logic        w_sclk_s, w_csb_s, w_sdi_s;
  logic        w_sclk_rise, w_sclk_fall, w_csb_fall, w_csb_rise;
  logic [15:0] w_instr;
  logic [7:0]  w_wr_byte;
  logic        w_instr_done, w_byte_done, w_last_byte, w_commit;

  // csb history resets low so a select already held low at reset release never looks like a new falling edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_csb_sync  <= '0;
      r_sdi_sync  <= '0;
      r_sclk_d    <= 1'b0;
      r_csb_d     <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_csb_sync  <= {r_csb_sync[SYNC_STAGES-2:0], csb};
      r_sdi_sync  <= {r_sdi_sync[SYNC_STAGES-2:0], sdi};
      r_sclk_d    <= w_sclk_s;
      r_csb_d     <= w_csb_s;
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_csb_s     = r_csb_sync[SYNC_STAGES-1];
  assign w_sdi_s     = r_sdi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
  assign w_csb_fall  = ~w_csb_s & r_csb_d;
  assign w_csb_rise  = w_csb_s & ~r_csb_d;

  assign w_instr      = {r_shift, w_sdi_s};
  assign w_wr_byte    = {r_wshift, w_sdi_s};
  assign w_instr_done = (r_state == S_INSTR) && w_sclk_rise && (r_bit_cnt == 4'd15);
  assign w_byte_done  = (r_state == S_DATA) && w_sclk_rise && (r_bit_cnt[2:0] == 3'd7);
  assign w_last_byte  = (r_w != 2'b11) && (r_byte_cnt == 2'd0);
  assign w_commit     = w_byte_done && !r_rw && !w_csb_rise;

  function automatic logic [7:0] rd_mux(input logic [12:0] a);
    case (a)
      13'h000: rd_mux = r_cfg;
      13'h001: rd_mux = CHIP_ID;
      13'h00B: rd_mux = r_shadow;
      default: rd_mux = 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_csb_fall) w_next = S_INSTR;
      S_INSTR: if (w_instr_done) w_next = S_DATA;
      S_DATA:  if (w_byte_done && w_last_byte) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_csb_rise) w_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt  <= 4'd0;
      r_shift    <= '0;
      r_wshift   <= '0;
      r_oshift   <= 8'h00;
      r_sdo      <= 1'b0;
      r_rw       <= 1'b0;
      r_w        <= 2'b00;
      r_byte_cnt <= 2'b00;
      r_addr     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_bit_cnt <= 4'd0;
          r_sdo     <= 1'b0;
        end
        S_INSTR: if (w_sclk_rise) begin
          r_shift <= w_instr[14:0];
          if (w_instr_done) begin
            r_bit_cnt  <= 4'd0;
            r_rw       <= w_instr[15];
            r_w        <= w_instr[14:13];
            r_byte_cnt <= w_instr[14:13];
            r_addr     <= w_instr[12:0];
            r_oshift   <= rd_mux(w_instr[12:0]);
          end else begin
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end
        end
        S_DATA: begin
          if (w_sclk_rise) begin
            r_wshift <= w_wr_byte[6:0];
            if (w_byte_done) begin
              r_bit_cnt  <= 4'd0;
              r_addr     <= r_addr - 13'd1;
              r_byte_cnt <= r_byte_cnt - 2'd1;
              r_oshift   <= rd_mux(r_addr - 13'd1);
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end else if (w_sclk_fall && r_rw) begin
            // bit7 of each byte appears on the falling edge that precedes its first rising edge
            r_sdo    <= r_oshift[7];
            r_oshift <= {r_oshift[6:0], 1'b0};
          end
        end
        default: r_bit_cnt <= 4'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cfg          <= 8'h18;
      r_shadow       <= 8'h00;
      register_value <= 8'h00;
      transfer_done  <= 1'b0;
      r_xfer_pend    <= 1'b0;
      r_srst_pend    <= 1'b0;
    end else begin
      transfer_done <= 1'b0;
      r_xfer_pend   <= 1'b0;
      r_srst_pend   <= 1'b0;
      if (r_srst_pend) begin
        r_cfg          <= 8'h18;
        r_shadow       <= 8'h00;
        register_value <= 8'h00;
      end else begin
        if (r_xfer_pend) begin
          register_value <= r_shadow;
          transfer_done  <= 1'b1;
        end
        if (w_commit) begin
          case (r_addr)
            13'h000: begin
              r_cfg       <= w_wr_byte & 8'hDB;
              r_srst_pend <= w_wr_byte[5] | w_wr_byte[2];
            end
            13'h00B: r_shadow    <= w_wr_byte;
            13'h0FF: r_xfer_pend <= w_wr_byte[0];
            default: ;
          endcase
        end
      end
    end
  end

  assign sdo_en    = (r_state == S_DATA) && r_rw && !w_csb_s;
  assign sdo       = sdo_en & r_sdo;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Self-checking bench for spi_reg_slave: directed scenarios plus random SPI transactions
// compared against a register-level model of the slave.
module tb_spi_reg_slave;

  localparam int HALF = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sclk = 1'b0;
  logic       csb = 1'b1;
  logic       sdi = 1'b0;
  logic       sdo, sdo_en, transfer_done;
  logic [7:0] register_value;
  logic [1:0] dbg_state;

  int checks = 0;
  int failures = 0;
  int td_count = 0;

  logic [7:0] wr_q[$];
  logic [7:0] exp_q[$];

  logic [7:0] m_cfg = 8'h18;
  logic [7:0] m_shadow = 8'h00;
  logic [7:0] m_regval = 8'h00;
  int         m_td = 0;

  spi_reg_slave #(.CHIP_ID(8'h82), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .csb(csb), .sdi(sdi),
    .sdo(sdo), .sdo_en(sdo_en), .register_value(register_value),
    .transfer_done(transfer_done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (transfer_done === 1'b1) td_count <= td_count + 1;

  initial begin
    #900000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_read(input logic [12:0] a);
    if (a == 13'h000) return m_cfg;
    if (a == 13'h001) return 8'h82;
    if (a == 13'h00B) return m_shadow;
    return 8'h00;
  endfunction

  task automatic m_reset();
    m_cfg = 8'h18; m_shadow = 8'h00; m_regval = 8'h00;
  endtask

  task automatic m_write(input logic [12:0] a, input logic [7:0] d);
    if (a == 13'h000) begin
      if (d[5] || d[2]) m_reset();
      else m_cfg = d;
    end else if (a == 13'h00B) begin
      m_shadow = d;
    end else if (a == 13'h0FF && d[0]) begin
      m_regval = m_shadow;
      m_td++;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic so, output logic en);
    sdi = b;
    wait_clk(HALF);
    so = sdo; en = sdo_en;
    sclk = 1'b1;
    wait_clk(HALF);
    sclk = 1'b0;
  endtask

  task automatic end_txn();
    wait_clk(HALF);
    csb = 1'b1;
    wait_clk(12);
    check("idle_sdo_en", sdo_en, 1'b0);
    check("idle_sdo", sdo, 1'b0);
  endtask

  // Sends one full transaction of nsent data bytes (wr_q supplies write data).
  task automatic spi_txn(input logic rw, input logic [1:0] w, input logic [12:0] a, input int nsent);
    logic [15:0] ins;
    logic [7:0]  d, rx;
    logic [12:0] ba;
    logic        so, en;
    int          en_cnt, eff;
    ins = {rw, w, a};
    en_cnt = 0;
    eff = (w == 2'b11) ? nsent : ((nsent < int'(w) + 1) ? nsent : int'(w) + 1);
    csb = 1'b0;
    wait_clk(HALF);
    for (int i = 15; i >= 0; i--) begin
      spi_bit(ins[i], so, en);
      if (en) en_cnt++;
    end
    for (int b = 0; b < nsent; b++) begin
      d = rw ? 8'h00 : wr_q[b];
      for (int i = 7; i >= 0; i--) begin
        spi_bit(d[i], so, en);
        rx[i] = so;
        if (en) en_cnt++;
      end
      ba = a - 13'(b);
      if (b < eff) begin
        if (rw) begin
          exp_q.push_back(m_read(ba));
          check("rd_data", rx, exp_q.pop_front());
        end else begin
          m_write(ba, d);
        end
      end else if (rw) begin
        check("rd_after_last", rx, 8'h00);
      end
    end
    end_txn();
    check("sdo_en_bits", en_cnt, rw ? 8 * eff : 0);
    check("register_value", register_value, m_regval);
    check("xfer_pulses", td_count, m_td);
    wr_q.delete();
  endtask

  task automatic wr1(input logic [12:0] a, input logic [7:0] d);
    wr_q.push_back(d);
    spi_txn(1'b0, 2'b00, a, 1);
  endtask

  task automatic rd1(input logic [12:0] a);
    spi_txn(1'b1, 2'b00, a, 1);
  endtask

  // Write to a that stops after nbits data bits; nothing is committed.
  task automatic spi_cut(input logic [12:0] a, input logic [7:0] d, input int nbits);
    logic [15:0] ins;
    logic        so, en;
    ins = {1'b0, 2'b00, a};
    csb = 1'b0;
    wait_clk(HALF);
    for (int i = 15; i >= 0; i--) spi_bit(ins[i], so, en);
    for (int i = 7; i > 7 - nbits; i--) spi_bit(d[i], so, en);
    end_txn();
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    logic [15:0] ins;
    logic [7:0]  d;
    logic        so, en;
    logic        rw;
    logic [1:0]  w;
    logic [12:0] a;
    int          n;

    wait_clk(4);
    check("rst_sdo", sdo, 1'b0);
    check("rst_sdo_en", sdo_en, 1'b0);
    check("rst_transfer_done", transfer_done, 1'b0);
    check("rst_register_value", register_value, 8'h00);
    reset = 1'b0;
    wait_clk(6);

    rd1(13'h000);
    rd1(13'h001);
    rd1(13'h00B);

    wr1(13'h00B, 8'h2B);
    check("regval_before_xfer", register_value, 8'h00);
    wr1(13'h0FF, 8'h01);
    check("regval_after_xfer", register_value, 8'h2B);
    check("xfer_single_pulse", td_count, 1);
    rd1(13'h0FF);

    wr_q.push_back(8'h05);
    wr_q.push_back(8'hAA);
    spi_txn(1'b0, 2'b11, 13'h00B, 2);
    rd1(13'h00B);
    rd1(13'h00A);

    spi_cut(13'h00B, 8'hF3, 5);
    rd1(13'h00B);
    spi_txn(1'b1, 2'b01, 13'h001, 2);
    spi_txn(1'b1, 2'b11, 13'h000, 2);
    wr_q.push_back(8'h77);
    wr_q.push_back(8'h66);
    spi_txn(1'b0, 2'b00, 13'h00B, 2);
    rd1(13'h00B);

    // reset during the data phase of a write of 8'h07; csb stays low through release
    ins = {1'b0, 2'b00, 13'h00B};
    d = 8'h07;
    csb = 1'b0;
    wait_clk(HALF);
    for (int i = 15; i >= 0; i--) spi_bit(ins[i], so, en);
    for (int i = 7; i >= 4; i--) spi_bit(d[i], so, en);
    reset = 1'b1;
    wait_clk(3);
    check("midrst_sdo", sdo, 1'b0);
    check("midrst_sdo_en", sdo_en, 1'b0);
    check("midrst_transfer_done", transfer_done, 1'b0);
    check("midrst_register_value", register_value, 8'h00);
    reset = 1'b0;
    m_reset();
    wait_clk(6);
    d = 8'h55;
    for (int i = 15; i >= 0; i--) spi_bit(ins[i], so, en);
    for (int i = 7; i >= 0; i--) spi_bit(d[i], so, en);
    end_txn();
    rd1(13'h00B);

    wr1(13'h00B, 8'h11);
    wr1(13'h0FF, 8'h01);
    check("regval_11", register_value, 8'h11);
    wr1(13'h000, 8'h24);
    check("soft_reset_regval", register_value, 8'h00);
    rd1(13'h000);
    rd1(13'h00B);

    for (int t = 0; t < 40; t++) begin
      rw = 1'($urandom_range(0, 1));
      w  = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: a = 13'h000;
        1: a = 13'h001;
        2: a = 13'h00B;
        3: a = 13'h0FF;
        4: a = 13'h00C;
        default: a = 13'($urandom);
      endcase
      n = (w == 2'b11) ? $urandom_range(1, 3) : int'(w) + 1 + $urandom_range(0, 1);
      for (int b = 0; b < n; b++) wr_q.push_back(8'($urandom));
      spi_txn(rw, w, a, n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_reg_slave.md
SPI_REG_SLAVE -- requirements
Module: spi_reg_slave

Interface
REQ-001 SHALL have parameter CHIP_ID, default 8'h82, value returned on reads of address 0x001.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the synchronizer depth applied to sclk, csb and sdi (legal values 2..3).
REQ-003 SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port sclk  input  1  SPI serial clock, asynchronous to clk, at most clk/8.
REQ-006 SHALL have port csb  input  1  SPI chip select, active low.
REQ-007 SHALL have port sdi  input  1  SPI serial data in.
REQ-008 SHALL have port sdo  output  1  SPI serial data out.
REQ-009 SHALL have port sdo_en  output  1  high while sdo is driven during a read data phase.
REQ-010 SHALL have port register_value  output  8  active clock-divide register: [2:0] divide ratio, [5:3] phase, [7:6] reserved.
REQ-011 SHALL have port transfer_done  output  1  one-clk pulse when the shadow registers are copied to active.

Function
REQ-012 SHALL pass sclk, csb and sdi through SYNC_STAGES flops, then detect sclk rising and falling edges from the last two synchronized samples.
REQ-013 SHALL implement FSM states IDLE, INSTR and DATA.
REQ-014 SHALL go IDLE->INSTR on synchronized csb falling, with the bit counter cleared.
REQ-015 SHALL, in INSTR, shift sdi in MSB first on each sclk rising edge, 16 bits total: bit15 R/W (1=read), bits14:13 W (byte count minus 1; 2'b11 = streaming), bits12:0 address.
REQ-016 SHALL go INSTR->DATA on the 16th rising edge, loading the byte counter with W and the address register with A.
REQ-017 SHALL, in DATA write mode, shift 8 bits MSB first; on the 8th rising edge the byte is committed to the addressed register in the same clk cycle.
REQ-018 SHALL, in DATA read mode, load the addressed register into the output shifter at the start of each byte, and update sdo on each sclk falling edge so that bit7 is valid before the first data rising edge.
REQ-019 SHALL decrement the address after each byte, wrapping 0x000->0x1FFF.
REQ-020 SHALL, when W!=2'b11, go DATA->IDLE after W+1 bytes and ignore further sclk edges until csb rises.
REQ-021 SHALL, when W=2'b11, continue streaming until csb rises.
REQ-022 SHALL return to IDLE whenever csb rises in any state, discarding a partial instruction or byte without committing it.
REQ-023 SHALL implement address 0x000 (config): R/W, reset 8'h18; bits [5] and [2] are write-only soft-reset bits that return all registers to reset values the cycle after the commit and self-clear.
REQ-024 SHALL implement address 0x001 (chip ID) as read-only returning CHIP_ID; writes are ignored.
REQ-025 SHALL implement address 0x00B (clock divide) as an R/W shadow register, reset 8'h00; reads return the shadow value.
REQ-026 SHALL implement address 0x0FF (transfer): writing with bit0=1 copies shadow 0x00B to register_value on the next clk and pulses transfer_done for one clk; bit0 self-clears and reads return 0x00.
REQ-027 SHALL ignore writes to unmapped addresses, and reads of unmapped addresses SHALL return 8'h00.
REQ-028 SHALL drive sdo_en high only in DATA read mode while csb is low; sdo SHALL be 0 whenever sdo_en is low.
REQ-029 SHALL change register_value only on a transfer, on reset, or on soft reset.

Reset
REQ-030 SHALL, on reset, asynchronously force state IDLE, counters 0, sdo=0, sdo_en=0, transfer_done=0, register_value=8'h00, shadow 0x00B=8'h00 and config=8'h18.
REQ-031 SHALL, on reset asserted mid-transfer, abort the transfer; after reset deassertion the block SHALL wait for a fresh csb falling edge before accepting data.

Verification
REQ-032 SHALL pass: write 0x00B=8'h2B, then 0x0FF=8'h01 -> register_value stays 8'h00 until the transfer commit, then becomes 8'h2B with a single transfer_done pulse.
REQ-033 SHALL pass: read 0x001 -> sdo shifts out 8'h82 MSB first with sdo_en high for exactly 8 sclk cycles.
REQ-034 SHALL pass: streaming write (W=11) at 0x00B with bytes 8'h05, 8'hAA -> 0x00B=8'h05, 0x00A is unmapped so it is ignored, and a readback of 0x00B returns 8'h05.
REQ-035 SHALL pass: csb raised after 5 data bits of a write to 0x00B -> the shadow is unchanged and the next transaction decodes correctly.
REQ-036 SHALL pass: reset asserted during the data phase of a write of 8'h07 -> all outputs are at reset values and a readback of 0x00B returns 8'h00.
REQ-037 SHALL pass: write 0x000=8'h24 after 0x00B=8'h11 was transferred -> register_value returns to 8'h00 and config reads 8'h18.
